// File: rtl/ultrasonic_detector.sv
// HC-SR04 initiator: periodic trigger, echo width measurement and near-object pulse.
// All outputs are registered; the echo pin is resynchronised before use.
module ultrasonic_detector #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned PERIOD_CYCLES  = 3000000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned THRESH_CYCLES  = 29000,
    parameter int unsigned W              = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         echo,
    output logic         trig,
    output logic         aux,
    output logic [W-1:0] echo_width,
    output logic         valid,
    output logic         timeout
);

    localparam longint unsigned MAX_COUNT =
        (PERIOD_CYCLES > TIMEOUT_CYCLES) ? 64'(PERIOD_CYCLES) : 64'(TIMEOUT_CYCLES);

    // Counters never saturate, so W must be wide enough for both period and timeout.
    if ((64'd1 << W) <= MAX_COUNT) begin : g_width_check
        $error("ultrasonic_detector: W too narrow for PERIOD_CYCLES/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_nxt;
    logic [W-1:0]   pcnt;
    logic [W-1:0]   width_nxt;
    logic           echo_m;
    logic           echo_s;
    logic           echo_d;
    logic           trig_nxt;
    logic           aux_nxt;
    logic           valid_nxt;
    logic           timeout_nxt;
    logic           start_c;
    logic           rise_c;
    logic           fall_c;

    assign start_c = (pcnt == W'(PERIOD_CYCLES - 1));
    assign rise_c  = echo_s & ~echo_d;
    assign fall_c  = ~echo_s & echo_d;

    // Echo synchroniser, edge-history flop and free-running period counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
            pcnt   <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
            pcnt   <= start_c ? '0 : pcnt + W'(1);
        end
    end

    // State, measurement counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            trig       <= 1'b0;
            aux        <= 1'b0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            echo_width <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            trig       <= trig_nxt;
            aux        <= aux_nxt;
            valid      <= valid_nxt;
            timeout    <= timeout_nxt;
            echo_width <= width_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        trig_nxt    = 1'b0;
        aux_nxt     = 1'b0;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        width_nxt   = echo_width;

        case (state)
            S_IDLE: begin
                if (start_c) begin
                    state_nxt = S_TRIG;
                    cnt_nxt   = '0;
                    trig_nxt  = 1'b1;
                end
            end
            S_TRIG: begin
                if (cnt == W'(TRIG_CYCLES - 1)) begin
                    state_nxt = S_WAIT_RISE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = cnt + W'(1);
                    trig_nxt = 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (rise_c) begin
                    state_nxt = S_MEASURE;
                    cnt_nxt   = W'(1);
                end else if (cnt == W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = S_IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + W'(1);
                end
            end
            S_MEASURE: begin
                // Timeout fires on the sample that would bring the width to TIMEOUT_CYCLES.
                if (fall_c) begin
                    state_nxt = S_DONE;
                end else if (echo_s) begin
                    if (cnt == W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt   = S_IDLE;
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                width_nxt = cnt;
                valid_nxt = 1'b1;
                aux_nxt   = (cnt < W'(THRESH_CYCLES));
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ultrasonic_detector.sv
// Scoreboard bench for ultrasonic_detector: per-period echo scenarios predict
// valid/timeout events from echo delay and width; a monitor checks every cycle.
module tb_ultrasonic_detector;

    localparam int TRIG    = 10;
    localparam int PERIOD  = 1000;
    localparam int TMO     = 400;
    localparam int THRESH  = 100;
    localparam int WB      = 12;

    localparam int K_NORMAL = 0;
    localparam int K_NONE   = 1;
    localparam int K_STUCK  = 2;
    localparam int K_RESET  = 3;

    logic          clk;
    logic          rst;
    logic          echo;
    logic          trig;
    logic          aux;
    logic [WB-1:0] echo_width;
    logic          valid;
    logic          timeout;

    typedef struct {
        bit is_valid;
        int edge_at;
        int width;
        bit aux;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    ultrasonic_detector #(
        .TRIG_CYCLES   (TRIG),
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TMO),
        .THRESH_CYCLES (THRESH),
        .W             (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .trig      (trig),
        .aux       (aux),
        .echo_width(echo_width),
        .valid     (valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        int   mbase;
        int   last_w;
        int   rel;
        logic r;
        exp_t e;
        mbase  = 0;
        last_w = 0;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            edge_n++;
            if (!r) begin
                mbase  = edge_n;
                last_w = 0;
                chk("reset_trig", int'(trig), 0);
                chk("reset_aux", int'(aux), 0);
                chk("reset_valid", int'(valid), 0);
                chk("reset_timeout", int'(timeout), 0);
                chk("reset_echo_width", int'(echo_width), 0);
            end else begin
                rel = edge_n - mbase;
                chk("trig", int'(trig), int'(rel >= PERIOD && (rel % PERIOD) < TRIG));
                chk("valid_and_timeout", int'(valid & timeout), 0);
                chk("aux_without_valid", int'(aux & ~valid), 0);
                if (valid || timeout) begin
                    if (q.size() == 0) begin
                        chk("unexpected_event", int'(valid | timeout), 0);
                    end else begin
                        e = q.pop_front();
                        chk("event_edge", edge_n, e.edge_at);
                        chk("event_is_valid", int'(valid), int'(e.is_valid));
                        if (e.is_valid) begin
                            chk("echo_width", int'(echo_width), e.width);
                            chk("aux", int'(aux), int'(e.aux));
                            last_w = e.width;
                        end else begin
                            chk("echo_width_kept", int'(echo_width), last_w);
                        end
                    end
                end else begin
                    chk("echo_width_hold", int'(echo_width), last_w);
                    if (q.size() > 0 && q[0].edge_at < edge_n) begin
                        e = q.pop_front();
                        chk("missing_event", edge_n, e.edge_at);
                    end
                end
            end
        end
    end

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic push_valid(input int at, input int w);
        exp_t e;
        e.is_valid = 1'b1;
        e.edge_at  = at;
        e.width    = w;
        e.aux      = (w < THRESH);
        q.push_back(e);
    endtask

    task automatic push_timeout(input int at);
        exp_t e;
        e.is_valid = 1'b0;
        e.edge_at  = at;
        e.width    = 0;
        e.aux      = 1'b0;
        q.push_back(e);
    endtask

    int base;
    int kidx;

    // One measurement period. Echo is driven so the pin is high for w edges starting at edge R.
    task automatic run_period(input int kind, input int d, input int w);
        int p;
        int f;
        int r;
        p = base + PERIOD * kidx;
        f = p + TRIG;
        case (kind)
            K_NORMAL: begin
                r = f + d;
                // Width below the timeout reports 3 edges after echo drops; otherwise timeout.
                if (w < TMO) push_valid(r + w + 3, w);
                else         push_timeout(r + TMO + 1);
                wait_edge(r - 1);
                echo = 1'b1;
                wait_edge(r + w - 1);
                echo = 1'b0;
                kidx++;
            end
            K_NONE: begin
                push_timeout(f + TMO);
                kidx++;
            end
            K_STUCK: begin
                push_timeout(f + TMO);
                wait_edge(p - 30);
                echo = 1'b1;
                wait_edge(f + TMO + 20);
                echo = 1'b0;
                kidx++;
            end
            default: begin
                r = f + 20;
                wait_edge(r - 1);
                echo = 1'b1;
                wait_edge(r + 50);
                rst = 1'b0;
                wait_edge(r + 51);
                rst  = 1'b1;
                base = r + 51;
                kidx = 1;
                wait_edge(r + 199);
                echo = 1'b0;
            end
        endcase
    endtask

    initial begin : stimulus
        int kinds[9]  = '{K_NORMAL, K_NORMAL, K_NORMAL, K_NORMAL, K_NONE, K_STUCK, K_NORMAL, K_RESET, K_NORMAL};
        int delays[9] = '{20, 20, 35, 5, 0, 0, 60, 0, 0};
        int widths[9] = '{50, 150, 100, 99, 0, 0, 500, 0, 1};
        int bw[6]     = '{1, 99, 100, 101, 399, 400};
        int sel;
        int w;
        rst  = 1'b0;
        echo = 1'b0;
        wait_edge(5);
        rst  = 1'b1;
        base = 5;
        kidx = 1;
        for (int i = 0; i < 9; i++) run_period(kinds[i], delays[i], widths[i]);
        for (int i = 0; i < 12; i++) begin
            sel = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) w = bw[$urandom_range(0, 5)];
            else                           w = int'($urandom_range(1, 450));
            if (sel == 0)      run_period(K_NONE, 0, 0);
            else if (sel == 1) run_period(K_STUCK, 0, 0);
            else               run_period(K_NORMAL, int'($urandom_range(0, 300)), w);
        end
        wait_edge(base + PERIOD * kidx - 1);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_detector.md
Name: ultrasonic_detector

Overview:
- Initiator side of the ultrasonic presence link: drives the HC-SR04 trigger, times the echo, and emits the one-cycle `aux` detection pulse.
- `aux` is consumed by the LED/sensor-flag hold stage.
- Detection means a measured echo shorter than a distance threshold.
- Sits between the sensor pins and the Tamagotchi interaction logic.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000: cycles from one trigger rising edge to the next (60 ms).
- TIMEOUT_CYCLES, 1500000: maximum wait for echo rise, and maximum echo high time, in cycles (30 ms).
- THRESH_CYCLES, 29000: echo widths strictly below this are a detection (~10 cm at 58 us/cm).
- W, 22: width of the counters and of `echo_width`.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-low
- echo  in  1  sensor echo pin, asynchronous
- trig  out  1  sensor trigger pin
- aux  out  1  one-cycle pulse: object within threshold
- echo_width  out  W  last valid echo high time in cycles
- valid  out  1  one-cycle pulse: `echo_width` updated
- timeout  out  1  one-cycle pulse: measurement aborted

Behaviour:

Reset and clocking:
- One clock; reset is synchronous and active-low.
- `rst`=0 sampled at a clk edge forces the following:
  - state IDLE, all counters 0
  - `trig`=0, `aux`=0, `valid`=0, `timeout`=0, `echo_width`=0
  - synchronizer flops 0
- Reset mid-measurement aborts with no pulse output.

Echo input:
- `echo` passes through a 2-flop synchronizer (`echo_s`), so 2 cycles of latency.
- Edges are detected on `echo_s` against its previous value.

Period counter:
- `pcnt` increments every cycle outside reset.
- When `pcnt` = PERIOD_CYCLES-1 it reloads 0 and raises `start`.
- The first `start` occurs PERIOD_CYCLES cycles after reset release.

States:
- IDLE: `trig`=0. On `start` go to TRIG; clear `cnt`.
- TRIG: `trig`=1.
  - `cnt` counts up; at `cnt`=TRIG_CYCLES-1 go to WAIT_RISE and clear `cnt`.
  - `trig` is high exactly TRIG_CYCLES cycles.
- WAIT_RISE: `trig`=0.
  - On `echo_s` rising edge go to MEASURE with `cnt`=1.
  - Else if `cnt` reaches TIMEOUT_CYCLES-1, pulse `timeout` and go to IDLE.
- MEASURE: `cnt` increments each cycle while `echo_s`=1.
  - On `echo_s` falling edge, go to DONE; the width counted is the number of cycles `echo_s` was high.
  - If `cnt` reaches TIMEOUT_CYCLES with echo still high, pulse `timeout`, go to IDLE, and do not update `echo_width`.
- DONE (one cycle):
  - `echo_width` <= `cnt`, `valid`=1.
  - `aux`=1 iff `cnt` < THRESH_CYCLES.
  - Go to IDLE.

Boundary conditions:
- `start` in any state other than IDLE is ignored (dropped, not queued).
- Echo already high when WAIT_RISE is entered is not a rising edge; the block waits for low then high, or times out.
- Width exactly THRESH_CYCLES gives no `aux`.
- `aux`, `valid` and `timeout` are each high for exactly one cycle, and `valid` and `timeout` are never high together.
- Counters saturate-free: W must hold PERIOD_CYCLES and TIMEOUT_CYCLES. Elaboration-time check: 2^W > max(PERIOD_CYCLES, TIMEOUT_CYCLES).

Test Plan:
All scenarios use TRIG_CYCLES=10, PERIOD_CYCLES=1000, TIMEOUT_CYCLES=400, THRESH_CYCLES=100, W=12.
- Reset: hold `rst`=0 for 5 cycles, then release → all outputs 0; first `trig` rise exactly 1000 cycles after release; `trig` high for exactly 10 cycles.
- Near object: echo rises 20 cycles after `trig` falls and stays high 50 cycles → `valid` pulse with `echo_width`=50, one-cycle `aux` in the same cycle.
- Far object: echo high 150 cycles → `valid`, `echo_width`=150, `aux` stays 0. Width of exactly 100 → `aux`=0; width of 99 → `aux`=1.
- No echo: `echo` held 0 → `timeout` pulse 400 cycles after `trig` falls; `echo_width` keeps its prior value; the next `trig` still occurs at the 1000-cycle period.
- Stuck echo: `echo` held 1 throughout → no MEASURE entry, `timeout` in WAIT_RISE. Echo rises, then stays high 500 cycles → `timeout` at 400 cycles of high time, no `valid`, no `aux`.
- Reset mid-MEASURE: assert `rst`=0 for 1 cycle → no `valid`, `aux` or `timeout`; `trig`=0; period restarts from 0.
